sram_pattern_checker: RTL

Self-checking SRAM exerciser for the feature-map SRAM path. It writes a parametrised incrementing pattern into a multi-bank dual-port SRAM through port A. It then reads the SRAM back through port B and compares every word, either against the regenerated pattern or against an externally streamed golden word. Results (pass, mismatch count, first failing address and data) are exposed as registers, so SRAM wiring and controller bring-up can be checked in silicon or emulation without a file-based bench.

---
 rtl/sram_pattern_checker.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_pattern_checker.sv
// SRAM exerciser: writes an incrementing pattern through port A, reads it back through
// port B and compares each word against the regenerated pattern or a streamed golden word.
module sram_pattern_checker #(
    parameter int SRAM_NUM = 4,
    parameter int WORD_W   = 16,
    parameter int ADDR_W   = 12,
    parameter int DEPTH    = 4096,
    parameter int ERR_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [WORD_W-1:0]          seed,
    output logic                       CENA,
    output logic [SRAM_NUM-1:0]        WENA,
    output logic [ADDR_W-1:0]          AA,
    output logic [SRAM_NUM*WORD_W-1:0] DA,
    output logic                       CENB,
    output logic [ADDR_W-1:0]          AB,
    input  logic [SRAM_NUM*WORD_W-1:0] QB,
    input  logic [SRAM_NUM*WORD_W-1:0] gold_data,
    input  logic                       gold_valid,
    output logic                       gold_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ERR_W-1:0]           err_cnt,
    output logic [ADDR_W-1:0]          first_err_addr,
    output logic [SRAM_NUM*WORD_W-1:0] first_err_got,
    output logic [SRAM_NUM*WORD_W-1:0] first_err_exp
);

    localparam int                DW        = SRAM_NUM * WORD_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_r;
    logic [1:0]          mode_r;
    logic [WORD_W-1:0]   seed_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                cena_r;
    logic [SRAM_NUM-1:0] wena_r;
    logic [ADDR_W-1:0]   aa_r;
    logic [DW-1:0]       da_r;
    logic                cenb_r;
    logic [ADDR_W-1:0]   ab_r;
    logic                gold_ready_r;
    logic                busy_r;
    logic                done_r;
    logic                pass_r;
    logic [ERR_W-1:0]    err_cnt_r;
    logic                first_seen_r;
    logic [ADDR_W-1:0]   first_addr_r;
    logic [DW-1:0]       first_got_r;
    logic [DW-1:0]       first_exp_r;
    logic                cmp_pend_r;
    logic [DW-1:0]       exp_r;
    logic [ADDR_W-1:0]   cmp_addr_r;

    logic                gold_rd_s;
    logic                rd_issue_s;
    logic                mismatch_s;
    logic [ERR_W-1:0]    err_next_s;
    logic [ADDR_W-1:0]   addr_inc_s;

    function automatic logic [DW-1:0] pattern_word(input logic [WORD_W-1:0] base,
                                                   input logic [ADDR_W-1:0] a);
        logic [DW-1:0] w;
        w = {DW{1'b0}};
        for (int b = 0; b < SRAM_NUM; b++) begin
            w[b*WORD_W +: WORD_W] = base + WORD_W'(a) + WORD_W'(b);
        end
        return w;
    endfunction

    // The golden-stream read must follow gold_valid in the same cycle, so CENB is
    // the registered enable gated by the live handshake.
    assign CENA           = cena_r;
    assign WENA           = wena_r;
    assign AA             = aa_r;
    assign DA             = da_r;
    assign CENB           = cenb_r & ~gold_rd_s;
    assign AB             = ab_r;
    assign gold_ready     = gold_ready_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign err_cnt        = err_cnt_r;
    assign first_err_addr = first_addr_r;
    assign first_err_got  = first_got_r;
    assign first_err_exp  = first_exp_r;

    // Read-issue decode, compare result and saturating error count.
    always_comb begin
        gold_rd_s  = 1'b0;
        rd_issue_s = 1'b0;
        if (state_r == S_READ) begin
            gold_rd_s  = (mode_r == 2'd1) && gold_valid;
            rd_issue_s = (mode_r != 2'd1) || gold_valid;
        end else begin
            gold_rd_s  = 1'b0;
            rd_issue_s = 1'b0;
        end
        addr_inc_s = addr_r + ADDR_W'(1);
        mismatch_s = cmp_pend_r && (QB != exp_r);
        if (mismatch_s && (err_cnt_r != {ERR_W{1'b1}})) begin
            err_next_s = err_cnt_r + ERR_W'(1);
        end else begin
            err_next_s = err_cnt_r;
        end
    end

    // Control FSM with registered SRAM strobes, compare pipeline and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            mode_r       <= 2'd0;
            seed_r       <= {WORD_W{1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
            cena_r       <= 1'b1;
            wena_r       <= {SRAM_NUM{1'b1}};
            aa_r         <= {ADDR_W{1'b0}};
            da_r         <= {DW{1'b0}};
            cenb_r       <= 1'b1;
            ab_r         <= {ADDR_W{1'b0}};
            gold_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            err_cnt_r    <= {ERR_W{1'b0}};
            first_seen_r <= 1'b0;
            first_addr_r <= {ADDR_W{1'b0}};
            first_got_r  <= {DW{1'b0}};
            first_exp_r  <= {DW{1'b0}};
            cmp_pend_r   <= 1'b0;
            exp_r        <= {DW{1'b0}};
            cmp_addr_r   <= {ADDR_W{1'b0}};
        end else begin
            done_r     <= 1'b0;
            cmp_pend_r <= 1'b0;
            err_cnt_r  <= err_next_s;
            if (mismatch_s && !first_seen_r) begin
                first_seen_r <= 1'b1;
                first_addr_r <= cmp_addr_r;
                first_got_r  <= QB;
                first_exp_r  <= exp_r;
            end
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        mode_r       <= mode;
                        seed_r       <= seed;
                        addr_r       <= {ADDR_W{1'b0}};
                        busy_r       <= 1'b1;
                        pass_r       <= 1'b0;
                        err_cnt_r    <= {ERR_W{1'b0}};
                        first_seen_r <= 1'b0;
                        first_addr_r <= {ADDR_W{1'b0}};
                        first_got_r  <= {DW{1'b0}};
                        first_exp_r  <= {DW{1'b0}};
                        if (mode == 2'd1) begin
                            state_r      <= S_READ;
                            gold_ready_r <= 1'b1;
                            ab_r         <= {ADDR_W{1'b0}};
                        end else begin
                            state_r <= S_WRITE;
                            cena_r  <= 1'b0;
                            wena_r  <= {SRAM_NUM{1'b0}};
                            aa_r    <= {ADDR_W{1'b0}};
                            da_r    <= pattern_word(seed, {ADDR_W{1'b0}});
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (addr_r == LAST_ADDR) begin
                        addr_r <= {ADDR_W{1'b0}};
                        cena_r <= 1'b1;
                        wena_r <= {SRAM_NUM{1'b1}};
                        if (mode_r == 2'd2) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                            pass_r  <= (err_next_s == {ERR_W{1'b0}});
                        end else begin
                            state_r <= S_READ;
                            cenb_r  <= 1'b0;
                            ab_r    <= {ADDR_W{1'b0}};
                        end
                    end else begin
                        addr_r <= addr_inc_s;
                        aa_r   <= addr_inc_s;
                        da_r   <= pattern_word(seed_r, addr_inc_s);
                    end
                end
                S_READ: begin
                    if (rd_issue_s) begin
                        cmp_pend_r <= 1'b1;
                        cmp_addr_r <= addr_r;
                        exp_r      <= (mode_r == 2'd1) ? gold_data : pattern_word(seed_r, addr_r);
                        if (addr_r == LAST_ADDR) begin
                            state_r      <= S_DRAIN;
                            cenb_r       <= 1'b1;
                            gold_ready_r <= 1'b0;
                        end else begin
                            addr_r <= addr_inc_s;
                            ab_r   <= addr_inc_s;
                        end
                    end else begin
                        state_r <= S_READ;
                    end
                end
                S_DRAIN: begin
                    state_r <= S_DONE;
                    done_r  <= 1'b1;
                    pass_r  <= (err_next_s == {ERR_W{1'b0}});
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r      <= S_IDLE;
                    busy_r       <= 1'b0;
                    cena_r       <= 1'b1;
                    wena_r       <= {SRAM_NUM{1'b1}};
                    cenb_r       <= 1'b1;
                    gold_ready_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
